// File: rtl/div.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient
// bit per clock over a runtime-selected width w, op_enable/op_finish handshake.
module div #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          op_enable,
  input  logic [$clog2(DATA_WIDTH):0]   in_width,
  input  logic [2*DATA_WIDTH-1:0]       in_div_a,
  input  logic [DATA_WIDTH-1:0]         in_div_b,
  output logic [DATA_WIDTH-1:0]         out_div_quotient,
  output logic [DATA_WIDTH-1:0]         out_div_remainder,
  output logic                          op_finish,
  output logic                          op_overflow
);

  localparam int unsigned N  = DATA_WIDTH;
  localparam int unsigned WW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t          state;
  logic [WW-1:0]   w_eff, w_r, cnt;
  logic [2*N-1:0]  a_mask, a_r;
  logic [N-1:0]    b_mask, b_r, lo_sh, quo, rem, h;
  logic [N:0]      r_next;
  logic            ge;

  always_comb begin
    w_eff = (in_width == '0 || 32'(in_width) > N) ? WW'(N) : in_width;
    a_mask = '0;
    b_mask = '0;
    for (int unsigned i = 0; i < 2*N; i++) a_mask[i] = (i < 2*32'(w_eff));
    for (int unsigned i = 0; i < N; i++)   b_mask[i] = (i < 32'(w_eff));
    h      = N'(a_r >> w_r);
    r_next = {rem, lo_sh[N-1]};
    ge     = (r_next >= {1'b0, b_r});
  end

  // The low half is pre-aligned so its bit w-1 sits at the MSB; bits at or
  // above w fall off the top during alignment, which doubles as masking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      w_r         <= '0;
      cnt         <= '0;
      a_r         <= '0;
      b_r         <= '0;
      lo_sh       <= '0;
      quo         <= '0;
      rem         <= '0;
      op_finish   <= 1'b0;
      op_overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (op_enable) begin
            w_r   <= w_eff;
            a_r   <= in_div_a & a_mask;
            b_r   <= in_div_b & b_mask;
            state <= LOAD;
          end
        end
        LOAD: begin
          quo <= '0;
          if (b_r == '0 || h >= b_r) begin
            rem         <= '0;
            op_overflow <= 1'b1;
            op_finish   <= 1'b1;
            state       <= DONE;
          end else begin
            rem   <= h;
            lo_sh <= a_r[N-1:0] << (N - 32'(w_r));
            cnt   <= w_r;
            state <= RUN;
          end
        end
        RUN: begin
          lo_sh <= lo_sh << 1;
          quo   <= {quo[N-2:0], ge};
          rem   <= ge ? N'(r_next - {1'b0, b_r}) : N'(r_next);
          cnt   <= cnt - 1'b1;
          if (cnt == WW'(1)) begin
            op_finish <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (!op_enable) begin
            op_finish   <= 1'b0;
            op_overflow <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_div_quotient  = quo;
  assign out_div_remainder = rem;

endmodule

// File: doc/div.md
# div

Sequential restoring integer divider, the inverse of the team's sequential `mult` block. It divides a double-width dividend (typically a `mult` product) by a single-width divisor, one quotient bit per clock, over a runtime-selectable operand width. It uses the same `op_enable`/`op_finish` handshake as `mult`, so the same controller can drive either block.

## Interface
- `DATA_WIDTH`, 32, maximum operand width N; dividend is 2N bits, divisor, quotient and remainder are N bits
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `op_enable`  in  1  start request; held high by the requester until `op_finish` is seen, then dropped
- `in_width`  in  $clog2(DATA_WIDTH)+1  active width w; legal range 1..N; 0 or >N is treated as N
- `in_div_a`  in  2N  dividend; bits at or above 2w are ignored (treated as 0)
- `in_div_b`  in  N  divisor; bits at or above w are ignored
- `out_div_quotient`  out  N  quotient; bits at or above w are 0
- `out_div_remainder`  out  N  remainder; bits at or above w are 0
- `op_finish`  out  1  result valid
- `op_overflow`  out  1  quotient does not fit in w bits, or divisor is zero; valid with `op_finish`

## Operation
- States: IDLE, LOAD, RUN, DONE. While `rst_n`=0, all of the following hold asynchronously: state=IDLE, all outputs 0, iteration counter 0.
- IDLE: on a rising edge with `op_enable`=1, register w, masked A and masked B, then go to LOAD. Inputs are not sampled after this edge.
- LOAD: with H = A[2w-1:w] and L = A[w-1:0]:
  - If B==0 or H>=B: go to DONE with `op_overflow`=1, quotient=0, remainder=0.
  - Otherwise: partial remainder R=H, shift register=L, counter=w, go to RUN.
- RUN, each cycle:
  - R' = {R, next MSB of L}, computed w+1 bits wide.
  - If R'>=B: R=R'-B and shift in quotient bit 1; else R=R' and shift in 0.
  - Decrement the counter. When the counter reaches 0, go to DONE.
- DONE: `op_finish`=1; quotient and remainder are driven from the registers. Stay in DONE while `op_enable`=1. On the first edge with `op_enable`=0, go to IDLE and clear `op_finish` and `op_overflow`.
- Quotient and remainder hold their values in IDLE until the next LOAD overwrites them.
- Invariant when not overflowed: A = Q·B + R, with R < B.
- `op_enable` dropping in LOAD or RUN is ignored. The operation completes, and DONE then exits on the next edge.

## Timing
- E0 = the edge on which IDLE samples `op_enable`=1.
- Normal division: `op_finish` rises after edge E0+w+1, i.e. w+1 cycles of latency (LOAD plus w RUN cycles). Outputs are final on that same edge.
- Overflow or zero divisor: `op_finish` and `op_overflow` rise after edge E0+1.
- `op_finish` falls after the first edge on which `op_enable`=0 in DONE. A new operation can be sampled on the following edge at the earliest.
- Asserting `rst_n` low mid-operation aborts immediately. After release, the block is IDLE and waits for `op_enable`; a still-high `op_enable` starts a fresh operation on the next edge.
- w=1: a single RUN cycle; `op_finish` rises after E0+2.

## Test plan
- N=32, w=8, A=1000, B=7 -> Q=142, R=6, overflow=0, `op_finish` rises 9 cycles after E0.
- w=8, A=1792 (0x0700), B=7 -> H=7>=B, so overflow=1, Q=0, R=0, `op_finish` rises 1 cycle after E0. Then w=4, B=0 -> overflow=1.
- w=32, A=0xFFFFFFFE00000001, B=0xFFFFFFFF -> Q=0xFFFFFFFF, R=0, latency 33 cycles. Also w=0 with the same operands -> identical result.
- Masking: w=4, A=0x10023, B=0x13 -> effective 35/3, so Q=11, R=2.
- Reset and handshake:
  - `rst_n` pulsed low during RUN -> all outputs 0 immediately, no `op_finish`.
  - `op_enable` held 5 cycles past `op_finish` -> outputs stable throughout.
  - `op_enable` dropped -> `op_finish` falls after 1 edge.
- Random: 5000 tests with random w in 2..32, A=a·b+r from random w-bit a, b≠0 and r<b -> Q=a, R=r, overflow=0, latency w+1. Pass count must equal 5000.
